// File: rtl/alu_mc.sv
`default_nettype none
// ==========================================================================
// alu_mc : RV integer ALU with single-cycle base ops and an optional
//          iterative M-extension unit (shift-add multiply, restoring divide).
// Rev 1.0
// ==========================================================================
module alu_mc #(
  parameter int XLEN   = 32,
  parameter int MDU_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] aluin1,
  input  logic [XLEN-1:0] aluin2,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic            mext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluout,
  output logic            busy
);
  localparam int c_sw = $clog2(XLEN);
  localparam int c_cw = c_sw + 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(XLEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_out, w_out_nxt, w_base;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic [c_sw-1:0]   w_shamt;
  logic              w_accept;
  logic              w_mdu_calc;
  logic [XLEN-1:0]   w_mdu_imm, w_mdu_res;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign aluout    = r_out;
  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = aluin2[c_sw-1:0];

  always_comb begin
    w_base = '0;
    case ({funct7, funct3})
      4'b0000: w_base = aluin1 + aluin2;
      4'b1000: w_base = aluin1 - aluin2;
      4'b0001: w_base = aluin1 << w_shamt;
      4'b0010: w_base = {{(XLEN-1){1'b0}}, $signed(aluin1) < $signed(aluin2)};
      4'b0011: w_base = {{(XLEN-1){1'b0}}, aluin1 < aluin2};
      4'b0100: w_base = aluin1 ^ aluin2;
      4'b0101: w_base = aluin1 >> w_shamt;
      4'b1101: w_base = $unsigned($signed(aluin1) >>> w_shamt);
      4'b0110: w_base = aluin1 | aluin2;
      4'b0111: w_base = aluin1 & aluin2;
      default: w_base = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_cnt_nxt = '0;
          if (mext && w_mdu_calc) begin
            w_state_nxt = CALC;
          end else begin
            w_state_nxt = DONE;
            w_out_nxt   = mext ? w_mdu_imm : w_base;
          end
        end
      end
      CALC: begin
        w_cnt_nxt = r_cnt + c_cw'(1);
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = DONE;
          w_out_nxt   = w_mdu_res;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  generate
    if (MDU_EN != 0) begin : g_mdu
      logic [XLEN-1:0]   r_hi, r_lo, r_m;
      logic [2:0]        r_f3;
      logic              r_neg_q, r_neg_r;
      logic              w_is_div, w_sgn_a, w_sgn_b, w_div0, w_ovf, w_ge;
      logic [XLEN-1:0]   w_mag_a, w_mag_b, w_sub, w_hi_nxt, w_lo_nxt, w_q, w_r;
      logic [XLEN:0]     w_sum, w_rs;
      logic [2*XLEN-1:0] w_prod_s;

      assign w_is_div = funct3[2];
      assign w_sgn_a  = aluin1[XLEN-1] & (w_is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]));
      assign w_sgn_b  = aluin2[XLEN-1] & (w_is_div ? ~funct3[0] : (~funct3[1] & funct3[0]));
      assign w_mag_a  = w_sgn_a ? -aluin1 : aluin1;
      assign w_mag_b  = w_sgn_b ? -aluin2 : aluin2;
      assign w_div0   = w_is_div && (aluin2 == '0);
      assign w_ovf    = w_is_div && !funct3[0] && (aluin1 == {1'b1, {(XLEN-1){1'b0}}}) && (&aluin2);
      assign w_mdu_calc = !(w_div0 || w_ovf);
      // On signed overflow the dividend itself is the most-negative quotient
      assign w_mdu_imm  = w_div0 ? (funct3[1] ? aluin1 : '1) : (funct3[1] ? '0 : aluin1);

      // Multiply: r_hi:r_lo is the running product; divide: r_hi remainder, r_lo quotient
      assign w_sum = {1'b0, r_hi} + ({1'b0, r_m} & {(XLEN+1){r_lo[0]}});
      assign w_rs  = {r_hi, r_lo[XLEN-1]};
      assign w_ge  = (w_rs >= {1'b0, r_m});
      assign w_sub = w_rs[XLEN-1:0] - r_m;

      always_comb begin
        if (r_f3[2]) begin
          w_hi_nxt = w_ge ? w_sub : w_rs[XLEN-1:0];
          w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end else begin
          w_hi_nxt = w_sum[XLEN:1];
          w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
      end

      assign w_prod_s = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
      assign w_q      = r_neg_q ? -w_lo_nxt : w_lo_nxt;
      assign w_r      = r_neg_r ? -w_hi_nxt : w_hi_nxt;

      always_comb begin
        if (r_f3[2])                 w_mdu_res = r_f3[1] ? w_r : w_q;
        else if (r_f3[1:0] == 2'b00) w_mdu_res = w_prod_s[XLEN-1:0];
        else                         w_mdu_res = w_prod_s[2*XLEN-1:XLEN];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hi    <= '0;
          r_lo    <= '0;
          r_m     <= '0;
          r_f3    <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else if (w_accept && mext) begin
          r_f3    <= funct3;
          r_hi    <= '0;
          r_m     <= w_is_div ? w_mag_b : w_mag_a;
          r_lo    <= w_is_div ? w_mag_a : w_mag_b;
          r_neg_q <= w_sgn_a ^ w_sgn_b;
          r_neg_r <= w_sgn_a;
        end else if (r_state == CALC) begin
          r_hi <= w_hi_nxt;
          r_lo <= w_lo_nxt;
        end
      end
    end else begin : g_no_mdu
      assign w_mdu_calc = 1'b0;
      assign w_mdu_imm  = '0;
      assign w_mdu_res  = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ==========================================================================
// tb_alu_mc : scoreboard bench for alu_mc (XLEN=32, MDU_EN=1).
// Rev 1.0
// ==========================================================================
module tb_alu_mc;
  logic        clk, rst_n, in_valid, in_ready, funct7, mext, out_valid, out_ready, busy;
  logic [31:0] aluin1, aluin2, aluout;
  logic [2:0]  funct3;

  typedef struct {
    int          id;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen = 0;

  alu_mc #(.XLEN(32), .MDU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluin1(aluin1), .aluin2(aluin2), .funct3(funct3), .funct7(funct7),
    .mext(mext), .out_valid(out_valid), .out_ready(out_ready),
    .aluout(aluout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: compares each new result presentation against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid && !seen) begin
      seen = 1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h exp=none", aluout);
      end else begin
        e = sb.pop_front();
        if (aluout !== e.exp) begin
          failures++;
          $display("FAIL result[id=%0d] got=%h exp=%h", e.id, aluout, e.exp);
        end
        checks++;
        if (cyc - e.acc != e.lat) begin
          failures++;
          $display("FAIL latency[id=%0d] got=%0d exp=%0d", e.id, cyc - e.acc, e.lat);
        end
      end
    end else if (!out_valid) begin
      seen = 0;
    end
  end

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic f7, input logic [2:0] f3, input logic m,
                       input logic [31:0] exp, input int lat);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout[id=%0d] got=0 exp=1", id);
      return;
    end
    aluin1 = a; aluin2 = b; funct7 = f7; funct3 = f3; mext = m; in_valid = 1'b1;
    sb.push_back('{id: id, exp: exp, lat: lat, acc: cyc});
    @(negedge clk);
    in_valid = 1'b0;
    aluin1 = $urandom; aluin2 = $urandom;
    funct3 = 3'($urandom); funct7 = 1'($urandom); mext = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluin1 = '0; aluin2 = '0; funct3 = '0; funct7 = 1'b0; mext = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_aluout",    aluout,             32'd0);
    rst_n = 1'b1;

    issue( 0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 3'd0, 1'b0, 32'h80000000, 1);
    issue( 1, 32'h00000000, 32'h00000001, 1'b1, 3'd0, 1'b0, 32'hFFFFFFFF, 1);
    issue( 2, 32'h80000000, 32'h00000024, 1'b1, 3'd5, 1'b0, 32'hF8000000, 1);
    issue( 3, 32'h80000000, 32'h00000024, 1'b0, 3'd5, 1'b0, 32'h08000000, 1);
    issue( 4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd2, 1'b0, 32'h00000001, 1);
    issue( 5, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd3, 1'b0, 32'h00000000, 1);
    issue( 6, 32'h00000001, 32'h00000021, 1'b0, 3'd1, 1'b0, 32'h00000002, 1);
    issue( 7, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'd4, 1'b0, 32'hFF00FF00, 1);
    issue( 8, 32'h0000000F, 32'h000000F0, 1'b0, 3'd6, 1'b0, 32'h000000FF, 1);
    issue( 9, 32'h000000FF, 32'h0000003C, 1'b0, 3'd7, 1'b0, 32'h0000003C, 1);
    issue(10, 32'hFFFFFFFF, 32'h00000003, 1'b1, 3'd1, 1'b0, 32'h00000000, 1);
    issue(11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'd3, 1'b1, 32'hFFFFFFFE, 33);
    issue(12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'd1, 1'b1, 32'h00000000, 33);
    issue(13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b1, 32'h00000001, 33);
    issue(14, 32'hFFFFFFFF, 32'h00000002, 1'b0, 3'd2, 1'b1, 32'hFFFFFFFF, 33);
    issue(15, 32'h00003039, 32'h00000064, 1'b0, 3'd0, 1'b1, 32'h0012D644, 33);
    issue(16, 32'h80000000, 32'hFFFFFFFF, 1'b0, 3'd4, 1'b1, 32'h80000000, 1);
    issue(17, 32'h80000000, 32'hFFFFFFFF, 1'b0, 3'd6, 1'b1, 32'h00000000, 1);
    issue(18, 32'h00000007, 32'h00000000, 1'b0, 3'd5, 1'b1, 32'hFFFFFFFF, 1);
    issue(19, 32'h00000007, 32'h00000000, 1'b0, 3'd7, 1'b1, 32'h00000007, 1);
    issue(20, 32'hFFFFFFF9, 32'h00000002, 1'b0, 3'd4, 1'b1, 32'hFFFFFFFD, 33);
    issue(21, 32'hFFFFFFF9, 32'h00000002, 1'b0, 3'd6, 1'b1, 32'hFFFFFFFF, 33);
    issue(22, 32'h00000064, 32'h00000007, 1'b0, 3'd5, 1'b1, 32'h0000000E, 33);
    issue(23, 32'h00000064, 32'h00000007, 1'b0, 3'd7, 1'b1, 32'h00000002, 33);
    issue(24, 32'hFFFFFFF9, 32'h00000000, 1'b0, 3'd6, 1'b1, 32'hFFFFFFF9, 1);
    issue(25, 32'h80000000, 32'h00000002, 1'b0, 3'd4, 1'b1, 32'hC0000000, 33);
    drain();

    // Consumer stalls in DONE while a competing request is presented
    out_ready = 1'b0;
    issue(30, 32'h00000010, 32'h00000020, 1'b0, 3'd0, 1'b0, 32'h00000030, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
      chk("hold_aluout",    aluout,             32'h00000030);
      aluin1 = 32'h1; aluin2 = 32'h1; funct3 = 3'd0; funct7 = 1'b0; mext = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    drain();

    // Abort a divide mid-CALC with an asynchronous reset
    issue(31, 32'hFFFFFFFF, 32'h00000003, 1'b0, 3'd5, 1'b1, 32'h55555555, 33);
    repeat (9) @(negedge clk);
    chk("calc_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",      {31'd0, busy},      32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_aluout",    aluout,             32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32, 32'h00000005, 32'h00000006, 1'b0, 3'd0, 1'b0, 32'h0000000B, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a power of two >= 8.
REQ-002 Parameter MDU_EN, default 1, SHALL enable the RV M-extension multiply/divide path when 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 aluin1  input  XLEN  operand 1 (rs1).
REQ-008 aluin2  input  XLEN  operand 2 (rs2/imm).
REQ-009 funct3  input  3  RV funct3.
REQ-010 funct7  input  1  RV funct7 bit 5 (SUB/SRA select).
REQ-011 mext  input  1  1 = M-extension op (funct7 = 0000001).
REQ-012 out_valid  output  1  aluout holds a result.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 aluout  output  XLEN  result.
REQ-015 busy  output  1  state != IDLE.

Function
REQ-016 SHALL implement states IDLE, CALC, DONE; in_ready = (state == IDLE); accept = in_valid && in_ready; operands and op code SHALL be captured at accept.
REQ-017 Base ops (mext=0), {funct7,funct3}: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; arithmetic modulo 2^XLEN.
REQ-018 Shift amount SHALL be aluin2[log2(XLEN)-1:0]; upper bits ignored.
REQ-019 SLT/SLTU SHALL return zero-extended 1 or 0.
REQ-020 Other base combinations (funct7=1, funct3 not 000/101) SHALL return 0, never X.
REQ-021 Base ops: IDLE -> DONE on accept; out_valid asserted the cycle after accept.
REQ-022 M ops (mext=1, MDU_EN=1), funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-023 Multiply: iterative shift-add on magnitudes with sign fixup, one partial product per cycle; IDLE -> CALC on accept, XLEN cycles in CALC, then DONE; out_valid at cycle XLEN+1 after accept.
REQ-024 Divide: restoring, one quotient bit per cycle, same XLEN-cycle CALC latency; quotient truncated toward zero, remainder sign = dividend sign.
REQ-025 Divide by zero: quotient all ones, remainder = dividend; signed overflow (min / -1): quotient = min, remainder = 0; both SHALL bypass CALC (latency 1, as REQ-021).
REQ-026 mext=1 with MDU_EN=0 SHALL return 0 with latency 1; no CALC logic instantiated.
REQ-027 CALC iteration counter width SHALL be log2(XLEN)+1; no wrap before completion.
REQ-028 DONE: out_valid=1, aluout stable; DONE -> IDLE when out_ready=1; out_valid deasserts the next cycle.
REQ-029 in_valid during CALC/DONE SHALL be ignored (in_ready=0); operand changes during CALC SHALL not affect the result.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, out_valid 0, aluout 0, busy 0, counter 0, in_ready 1, aborting any operation mid-CALC or DONE.
REQ-031 After rst_n rises, first accept possible on the first rising edge with in_valid=1.

Verification (XLEN=32)
REQ-032 ADD 0x7FFFFFFF + 0x00000001 -> aluout 0x80000000, out_valid 1 cycle after accept; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-033 SRA 0x80000000, aluin2 0x00000024 -> 0xF8000000; SRL same -> 0x08000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-034 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0x00000000; MUL same -> 0x00000001; out_valid exactly 33 cycles after accept.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 (latency 1); REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-036 out_ready held 0 for 5 cycles in DONE -> aluout, out_valid stable, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-037 rst_n pulsed low at CALC cycle 10 of DIVU -> out_valid 0, busy 0 immediately; after release a new ADD completes normally.
